// File: rtl/turbo_pifo_pkg.sv
// Shared types and widths for the Turbo PIFO pop-side merge stage.
// An entry is {rank, payload}; a smaller rank is served first.
package turbo_pifo_pkg;
  localparam int MTW       = 16;
  localparam int PTW       = 32;
  localparam int DW        = MTW + PTW;
  localparam int NUM_PIPES = 2;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_PENDING = 2'd1,
    S_FULL    = 2'd2
  } slot_st_e;

  function automatic logic [MTW-1:0] rank_of(input logic [DW-1:0] data);
    return data[DW-1 -: MTW];
  endfunction
endpackage

// File: rtl/turbo_pop_merger_if.sv
// Bus bundle between the merge stage, the push dispatcher, both PIFO pipelines and the consumer.
// The slave view belongs to the merge stage; the master view to its surroundings.
interface turbo_pop_merger_if;
  import turbo_pifo_pkg::*;

  logic          i_p0_push, i_p1_push;
  logic [DW-1:0] i_p0_push_data, i_p1_push_data;
  logic          o_p0_push, o_p1_push;
  logic [DW-1:0] o_p0_push_data, o_p1_push_data;
  logic          o_p0_pop, o_p1_pop;
  logic          i_p0_valid, i_p1_valid;
  logic [DW-1:0] i_p0_data, i_p1_data;
  logic          i_p0_empty, i_p1_empty;
  logic          i_pop;
  logic          o_ready;
  logic          o_pop_valid;
  logic [DW-1:0] o_pop_data;
  logic          o_empty;
  logic          o_err;

  modport slave (
    input  i_p0_push, i_p0_push_data, i_p1_push, i_p1_push_data,
    input  i_p0_valid, i_p0_data, i_p0_empty, i_p1_valid, i_p1_data, i_p1_empty,
    input  i_pop,
    output o_p0_push, o_p0_push_data, o_p1_push, o_p1_push_data,
    output o_p0_pop, o_p1_pop,
    output o_ready, o_pop_valid, o_pop_data, o_empty, o_err
  );

  modport master (
    output i_p0_push, i_p0_push_data, i_p1_push, i_p1_push_data,
    output i_p0_valid, i_p0_data, i_p0_empty, i_p1_valid, i_p1_data, i_p1_empty,
    output i_pop,
    input  o_p0_push, o_p0_push_data, o_p1_push, o_p1_push_data,
    input  o_p0_pop, o_p1_pop,
    input  o_ready, o_pop_valid, o_pop_data, o_empty, o_err
  );
endinterface

// File: rtl/turbo_head_slot.sv
// One-entry head cache for a single PIFO pipeline: keeps the pipeline's true minimum
// by swapping with dispatched pushes and refilling from the pipeline after a pop.
module turbo_head_slot
  import turbo_pifo_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_arst_n,
  input  logic          i_push,
  input  logic [DW-1:0] i_push_data,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  input  logic          i_pipe_empty,
  input  logic          i_sel,
  output slot_st_e      o_st,
  output logic [DW-1:0] o_head,
  output logic          o_hold,
  output logic          o_pipe_push,
  output logic [DW-1:0] o_pipe_push_data,
  output logic          o_pipe_pop,
  output logic          o_err
);
  slot_st_e      st_q, st_d;
  logic [DW-1:0] head_q, head_d, hold_q, hold_d, fwd_data_q, fwd_data_d;
  logic          hold_vld_q, hold_vld_d, fwd_q, fwd_d;
  logic          push_prev_q, push_prev_d, run_q, run_d;
  logic          refill;

  // A push forwarded this cycle has not reached the pipeline's empty flag yet.
  assign refill = run_q && !i_push && !i_pipe_empty && !fwd_q;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) st_q <= S_EMPTY;
    else           st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      S_EMPTY:   if (i_push) st_d = S_FULL; else if (refill) st_d = S_PENDING;
      S_PENDING: if (i_valid) st_d = S_FULL;
      S_FULL:    if (i_sel) st_d = S_EMPTY;
      default:   st_d = S_EMPTY;
    endcase
  end

  always_comb begin
    o_pipe_pop = (st_q == S_EMPTY) && refill;
    o_err      = (i_valid && st_q != S_PENDING) || (i_push && push_prev_q) ||
                 (st_q == S_PENDING && !i_valid);
  end

  always_comb begin
    head_d      = head_q;
    hold_d      = hold_q;
    hold_vld_d  = hold_vld_q;
    fwd_d       = 1'b0;
    fwd_data_d  = fwd_data_q;
    push_prev_d = i_push;
    run_d       = 1'b1;
    case (st_q)
      S_EMPTY: if (i_push) head_d = i_push_data;
      S_PENDING: begin
        if (i_valid) head_d = i_data;
        if (i_push) begin
          hold_d     = i_push_data;
          hold_vld_d = 1'b1;
        end
      end
      S_FULL: begin
        if (hold_vld_q) begin
          hold_vld_d = 1'b0;
          fwd_d      = 1'b1;
          if (rank_of(hold_q) < rank_of(head_q)) begin
            fwd_data_d = head_q;
            head_d     = hold_q;
          end else begin
            fwd_data_d = hold_q;
          end
        end else if (i_push) begin
          fwd_d = 1'b1;
          // strict compare: equal ranks stay in arrival order
          if (!i_sel && rank_of(i_push_data) < rank_of(head_q)) begin
            fwd_data_d = head_q;
            head_d     = i_push_data;
          end else begin
            fwd_data_d = i_push_data;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      head_q      <= '0;
      hold_q      <= '0;
      hold_vld_q  <= 1'b0;
      fwd_q       <= 1'b0;
      fwd_data_q  <= '0;
      push_prev_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      head_q      <= head_d;
      hold_q      <= hold_d;
      hold_vld_q  <= hold_vld_d;
      fwd_q       <= fwd_d;
      fwd_data_q  <= fwd_data_d;
      push_prev_q <= push_prev_d;
      run_q       <= run_d;
    end
  end

  assign o_st             = st_q;
  assign o_head           = head_q;
  assign o_hold           = hold_vld_q;
  assign o_pipe_push      = fwd_q;
  assign o_pipe_push_data = fwd_data_q;
endmodule

// File: rtl/turbo_pop_merger.sv
// Pop-side merge of the two Turbo PIFO pipelines: two head caches, a min-compare
// across them, and the registered consumer result.
module turbo_pop_merger
  import turbo_pifo_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_arst_n,
  turbo_pop_merger_if.slave bus
);
  logic [NUM_PIPES-1:0]         push_in, valid_in, empty_in, sel, full, ok, fwd, pipe_pop, hold, err;
  logic [NUM_PIPES-1:0][DW-1:0] push_data_in, data_in, head, fwd_data;
  slot_st_e                     st [NUM_PIPES];
  logic                         accept, pick1, ready;
  logic                         pop_valid_q, pop_valid_d, err_q, err_d;
  logic [DW-1:0]                pop_data_q, pop_data_d;

  assign push_in      = {bus.i_p1_push, bus.i_p0_push};
  assign push_data_in = {bus.i_p1_push_data, bus.i_p0_push_data};
  assign valid_in     = {bus.i_p1_valid, bus.i_p0_valid};
  assign data_in      = {bus.i_p1_data, bus.i_p0_data};
  assign empty_in     = {bus.i_p1_empty, bus.i_p0_empty};

  for (genvar g = 0; g < NUM_PIPES; g++) begin : g_slot
    turbo_head_slot u_slot (
      .i_clk            (i_clk),
      .i_arst_n         (i_arst_n),
      .i_push           (push_in[g]),
      .i_push_data      (push_data_in[g]),
      .i_valid          (valid_in[g]),
      .i_data           (data_in[g]),
      .i_pipe_empty     (empty_in[g]),
      .i_sel            (sel[g]),
      .o_st             (st[g]),
      .o_head           (head[g]),
      .o_hold           (hold[g]),
      .o_pipe_push      (fwd[g]),
      .o_pipe_push_data (fwd_data[g]),
      .o_pipe_pop       (pipe_pop[g]),
      .o_err            (err[g])
    );
    // a head still resolving a held push is not yet known to be the minimum
    assign full[g] = (st[g] == S_FULL) && !hold[g];
    assign ok[g]   = full[g] || (st[g] == S_EMPTY && empty_in[g] && !fwd[g] && !hold[g]);
  end

  always_comb begin
    pick1       = full[1] && (!full[0] || rank_of(head[1]) < rank_of(head[0]));
    ready       = (|full) && (&ok);
    accept      = bus.i_pop && ready;
    sel         = '0;
    if (accept) sel[pick1] = 1'b1;
    pop_valid_d = accept;
    pop_data_d  = accept ? head[pick1] : pop_data_q;
    err_d       = err_q || (|err);
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      pop_valid_q <= pop_valid_d;
      pop_data_q  <= pop_data_d;
      err_q       <= err_d;
    end
  end

  assign bus.o_ready        = ready;
  assign bus.o_pop_valid    = pop_valid_q;
  assign bus.o_pop_data     = pop_data_q;
  assign bus.o_err          = err_q;
  assign bus.o_empty        = (st[0] == S_EMPTY) && (st[1] == S_EMPTY) && (&empty_in);
  assign bus.o_p0_push      = fwd[0];
  assign bus.o_p1_push      = fwd[1];
  assign bus.o_p0_push_data = fwd_data[0];
  assign bus.o_p1_push_data = fwd_data[1];
  assign bus.o_p0_pop       = pipe_pop[0];
  assign bus.o_p1_pop       = pipe_pop[1];
endmodule

// File: tb/tb_turbo_pop_merger.sv
// Directed bench for turbo_pop_merger: behavioural pipelines, a pop scoreboard
// fed by the stimulus, and a monitor that checks every o_pop_valid.
module tb_turbo_pop_merger;
  import turbo_pifo_pkg::*;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  turbo_pop_merger_if bus ();

  turbo_pop_merger dut (
    .i_clk    (clk),
    .i_arst_n (arst_n),
    .bus      (bus)
  );

  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] expq[$];
  logic [DW-1:0] q0[$], q1[$];
  logic          pp0, pp1, ps0, ps1, inj0;
  logic [DW-1:0] pd0, pd1;

  function automatic logic [DW-1:0] ent(input int r, input int p);
    logic [31:0] rr, pv;
    rr = r;
    pv = p;
    return {rr[MTW-1:0], pv[PTW-1:0]};
  endfunction

  function automatic int ins_pos(input logic [DW-1:0] q[$], input logic [DW-1:0] d);
    for (int k = 0; k < q.size(); k++)
      if (q[k][DW-1 -: MTW] > d[DW-1 -: MTW]) return k;
    return q.size();
  endfunction

  // pipeline model: sorted, FIFO among equal ranks, pop answered one cycle later
  always @(negedge clk) begin
    pp0 = bus.o_p0_pop;  pp1 = bus.o_p1_pop;
    ps0 = bus.o_p0_push; ps1 = bus.o_p1_push;
    pd0 = bus.o_p0_push_data; pd1 = bus.o_p1_push_data;
  end

  always @(posedge clk) begin
    #1;
    if (!arst_n) begin
      q0.delete(); q1.delete();
      bus.i_p0_valid = 1'b0; bus.i_p1_valid = 1'b0;
      bus.i_p0_data = '0;    bus.i_p1_data = '0;
    end else begin
      bus.i_p0_valid = pp0 | inj0;
      bus.i_p1_valid = pp1;
      if (pp0 && q0.size() != 0) bus.i_p0_data = q0.pop_front();
      if (pp1 && q1.size() != 0) bus.i_p1_data = q1.pop_front();
      if (ps0) q0.insert(ins_pos(q0, pd0), pd0);
      if (ps1) q1.insert(ins_pos(q1, pd1), pd1);
    end
    bus.i_p0_empty = (q0.size() == 0);
    bus.i_p1_empty = (q1.size() == 0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int p, input logic [DW-1:0] d);
    if (p == 0) begin bus.i_p0_push = 1'b1; bus.i_p0_push_data = d; end
    else        begin bus.i_p1_push = 1'b1; bus.i_p1_push_data = d; end
    step();
    bus.i_p0_push = 1'b0;
    bus.i_p1_push = 1'b0;
  endtask

  task automatic pop_req(input logic [DW-1:0] exp);
    int n;
    n = 0;
    bus.i_pop = 1'b1;
    #1;
    while (!bus.o_ready && n < 40) begin step(); n++; #1; end
    if (!bus.o_ready) begin
      n_vec++; n_err++;
      $display("FAIL pop_timeout: o_ready stayed 0, expected entry %h", exp);
    end else begin
      expq.push_back(exp);
    end
    step();
    bus.i_pop = 1'b0;
  endtask

  initial begin
    int w;
    arst_n = 1'b0;
    inj0 = 1'b0;
    bus.i_p0_push = 1'b0; bus.i_p0_push_data = '0;
    bus.i_p1_push = 1'b0; bus.i_p1_push_data = '0;
    bus.i_pop = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (arst_n && bus.o_pop_valid) begin
          n_vec++;
          if (expq.size() == 0) begin
            n_err++;
            $display("FAIL pop_unexpected: got %h with nothing expected", bus.o_pop_data);
          end else begin
            logic [DW-1:0] e;
            e = expq.pop_front();
            if (bus.o_pop_data !== e) begin
              n_err++;
              $display("FAIL pop_data: got %h expected %h", bus.o_pop_data, e);
            end
          end
        end
      end
    join_none

    repeat (3) step();
    chk1("rst_p0_push", bus.o_p0_push, 1'b0);
    chkd("rst_p0_push_data", bus.o_p0_push_data, '0);
    chk1("rst_p0_pop", bus.o_p0_pop, 1'b0);
    chk1("rst_pop_valid", bus.o_pop_valid, 1'b0);
    chkd("rst_pop_data", bus.o_pop_data, '0);
    chk1("rst_err", bus.o_err, 1'b0);
    chk1("rst_ready", bus.o_ready, 1'b0);
    chk1("rst_empty", bus.o_empty, 1'b1);
    arst_n = 1'b1;
    step();

    // direct cache of a push into an empty slot
    push(0, ent(5, 'hA5));
    chk1("t1_no_fwd", bus.o_p0_push, 1'b0);
    chk1("t1_not_empty", bus.o_empty, 1'b0);
    step();
    pop_req(ent(5, 'hA5));
    chk1("t1_empty_after", bus.o_empty, 1'b1);

    // p0 {3,7}, p1 {4}: pops 3, 4, 7
    push(0, ent(3, 'h03));
    step();
    push(0, ent(7, 'h07));
    chk1("t2_fwd7", bus.o_p0_push, 1'b1);
    chkd("t2_fwd7_data", bus.o_p0_push_data, ent(7, 'h07));
    push(1, ent(4, 'h04));
    step();
    pop_req(ent(3, 'h03));
    chk1("t2_refill_pop", bus.o_p0_pop, 1'b1);
    pop_req(ent(4, 'h04));
    pop_req(ent(7, 'h07));
    chk1("t2_empty_after", bus.o_empty, 1'b1);

    // swap on a smaller push, no swap on an equal rank
    push(0, ent(10, 'h10));
    step();
    push(0, ent(2, 'h22));
    chk1("t3_swap_fwd", bus.o_p0_push, 1'b1);
    chkd("t3_swap_data", bus.o_p0_push_data, ent(10, 'h10));
    step();
    push(0, ent(2, 'h33));
    chk1("t3_eq_fwd", bus.o_p0_push, 1'b1);
    chkd("t3_eq_data", bus.o_p0_push_data, ent(2, 'h33));
    step();
    pop_req(ent(2, 'h22));
    pop_req(ent(2, 'h33));
    pop_req(ent(10, 'h10));

    // equal heads: pipe 0 first
    bus.i_p0_push = 1'b1; bus.i_p0_push_data = ent(6, 'h60);
    bus.i_p1_push = 1'b1; bus.i_p1_push_data = ent(6, 'h61);
    step();
    bus.i_p0_push = 1'b0; bus.i_p1_push = 1'b0;
    step();
    pop_req(ent(6, 'h60));
    pop_req(ent(6, 'h61));

    // pop held off while p1 refills; a push lands in the hold during PENDING
    push(1, ent(9, 'h90));
    step();
    push(1, ent(1, 'h91));
    chkd("t5_swap_data", bus.o_p1_push_data, ent(9, 'h90));
    push(0, ent(5, 'h50));
    step();
    pop_req(ent(1, 'h91));
    bus.i_pop = 1'b1;
    #1;
    chk1("t5_ready_refill", bus.o_ready, 1'b0);
    chk1("t5_p1_pop", bus.o_p1_pop, 1'b1);
    step();
    chk1("t5_no_valid", bus.o_pop_valid, 1'b0);
    chk1("t5_ready_pending", bus.o_ready, 1'b0);
    bus.i_p1_push = 1'b1; bus.i_p1_push_data = ent(0, 'h92);
    step();
    bus.i_p1_push = 1'b0;
    #1;
    chk1("t5_ready_hold", bus.o_ready, 1'b0);
    pop_req(ent(0, 'h92));
    pop_req(ent(5, 'h50));
    pop_req(ent(9, 'h90));
    chk1("t5_no_err", bus.o_err, 1'b0);

    // consecutive pushes to p1 raise a sticky error; reset clears everything
    bus.i_p1_push = 1'b1; bus.i_p1_push_data = ent(11, 'hB1);
    step();
    bus.i_p1_push_data = ent(12, 'hB2);
    step();
    bus.i_p1_push = 1'b0;
    chk1("t6_err_set", bus.o_err, 1'b1);
    chk1("t6_fwd", bus.o_p1_push, 1'b1);
    step();
    chk1("t6_err_sticky", bus.o_err, 1'b1);
    arst_n = 1'b0;
    #1;
    chk1("t6_rst_err", bus.o_err, 1'b0);
    chkd("t6_rst_push_data", bus.o_p1_push_data, '0);
    chkd("t6_rst_pop_data", bus.o_pop_data, '0);
    chk1("t6_rst_pop_valid", bus.o_pop_valid, 1'b0);
    chk1("t6_rst_p1_pop", bus.o_p1_pop, 1'b0);
    repeat (2) step();
    arst_n = 1'b1;
    step();

    // stray pipeline response
    inj0 = 1'b1;
    step();
    inj0 = 1'b0;
    chk1("t7_err_not_yet", bus.o_err, 1'b0);
    step();
    chk1("t7_err_stray_valid", bus.o_err, 1'b1);

    w = 0;
    while (expq.size() != 0 && w < 20) begin step(); w++; end
    n_vec++;
    if (expq.size() != 0) begin
      n_err++;
      $display("FAIL pops_outstanding: got %0d left expected 0", expq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
